// File: rtl/cfg_bus_master.sv
// cfg_bus_master: single initiator for the nibble-serial bidirectional config bus.
// Converts one parallel read/write request into a framed serial transaction
// (command beat, address beats, then write-data beats or turnaround + read-data
// beats) and returns a one-cycle response pulse with the read data.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_write/req_addr/req_wdata captured on accept
//   rsp_valid/rsp_rdata   one-cycle completion pulse; read data (0 for writes), held until next completion
//   busy                  transaction in progress (inverse of req_ready)
//   cfg_frame             high for every bus cycle of a transaction
//   cfg_bus               bidirectional config bus, driven only in CMD/ADDR/WDATA
module cfg_bus_master #(
  parameter int unsigned BUS_W      = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              cfg_frame,
  inout  wire  [BUS_W-1:0]  cfg_bus
);

  localparam int unsigned A_BEATS   = ADDR_W / BUS_W;
  localparam int unsigned D_BEATS   = DATA_W / BUS_W;
  localparam int unsigned AD_MAX    = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
  localparam int unsigned MAX_BEATS = (AD_MAX > TURNAROUND) ? AD_MAX : TURNAROUND;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS) + 1;
  localparam int unsigned TX_W      = ADDR_W + DATA_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_TURN  = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wr_q;
  logic [TX_W-1:0]   tx_sh;
  logic [DATA_W-1:0] rd_sh;
  logic [BUS_W-1:0]  dout, dout_nxt;
  logic              oe, oe_nxt;
  logic              frame_nxt;
  logic              accept_c;
  logic              pop_c;
  logic [BUS_W-1:0]  cmd_beat_c;
  logic [DATA_W-1:0] rd_cat_c;

  // Master drives only from registered data/enable; released otherwise.
  assign cfg_bus = oe ? dout : {BUS_W{1'bz}};

  // Next state, beat counter and next values of the registered bus outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept_c   = req_valid & req_ready;
    cmd_beat_c = '0;
    cmd_beat_c[BUS_W-1] = 1'b1;
    cmd_beat_c[BUS_W-2] = req_write;
    rd_cat_c   = DATA_W'({rd_sh, cfg_bus});

    case (state)
      S_IDLE:  if (accept_c) state_nxt = S_CMD;
      S_CMD: begin
        state_nxt = S_ADDR;
        cnt_nxt   = CNT_W'(A_BEATS - 1);
      end
      S_ADDR: begin
        if (cnt == '0) begin
          if (wr_q) begin
            state_nxt = S_WDATA;
            cnt_nxt   = CNT_W'(D_BEATS - 1);
          end else begin
            state_nxt = S_TURN;
            cnt_nxt   = CNT_W'(TURNAROUND - 1);
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_WDATA: begin
        if (cnt == '0) state_nxt = S_DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_TURN: begin
        if (cnt == '0) begin
          state_nxt = S_RDATA;
          cnt_nxt   = CNT_W'(D_BEATS - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_RDATA: begin
        if (cnt == '0) state_nxt = S_DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    frame_nxt = (state_nxt == S_CMD) || (state_nxt == S_ADDR) || (state_nxt == S_WDATA) ||
                (state_nxt == S_TURN) || (state_nxt == S_RDATA);
    oe_nxt    = (state_nxt == S_CMD) || (state_nxt == S_ADDR) || (state_nxt == S_WDATA);
    // Address and write data share one shift register, so each driven beat just pops the top.
    pop_c     = (state_nxt == S_ADDR) || (state_nxt == S_WDATA);

    dout_nxt = dout;
    if (state_nxt == S_CMD) dout_nxt = cmd_beat_c;
    else if (pop_c)         dout_nxt = tx_sh[TX_W-1 -: BUS_W];
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      tx_sh     <= '0;
      rd_sh     <= '0;
      dout      <= '0;
      oe        <= 1'b0;
      cfg_frame <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dout      <= dout_nxt;
      oe        <= oe_nxt;
      cfg_frame <= frame_nxt;
      req_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      rsp_valid <= (state_nxt == S_DONE);

      if (accept_c) begin
        wr_q  <= req_write;
        tx_sh <= {req_addr, req_wdata};
        rd_sh <= '0;
      end else if (pop_c) begin
        tx_sh <= tx_sh << BUS_W;
      end

      // Sample at the end of each read-data cycle; value taken as-is.
      if (state == S_RDATA) rd_sh <= rd_cat_c;

      if (state_nxt == S_DONE) rsp_rdata <= wr_q ? '0 : rd_cat_c;
    end
  end

endmodule

// File: tb/tb_cfg_bus_master.sv
// tb_cfg_bus_master: directed bench for cfg_bus_master.
// Instance u_dut1 uses TURNAROUND=1, u_dut2 uses TURNAROUND=3. Each bus has
// pull-ups so a released bus reads 4'hF; a bench target drives read data.
module tb_cfg_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid1, req_valid2;
  logic       req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rr1, rv1, busy1, fr1;
  logic       rr2, rv2, busy2, fr2;
  logic [7:0] rd1, rd2;
  wire  [3:0] bus1, bus2;
  logic       t_oe1, t_oe2;
  logic [3:0] t_d;

  int n_chk  = 0;
  int n_fail = 0;
  int sel    = 0;

  logic [3:0] o_bus;
  logic       o_frame, o_valid, o_ready, o_busy;
  logic [7:0] o_rdata;

  assign bus1 = t_oe1 ? t_d : 4'bzzzz;
  assign bus2 = t_oe2 ? t_d : 4'bzzzz;

  for (genvar i = 0; i < 4; i++) begin : g_pull
    pullup (bus1[i]);
    pullup (bus2[i]);
  end

  assign o_bus   = (sel == 1) ? bus2  : bus1;
  assign o_frame = (sel == 1) ? fr2   : fr1;
  assign o_valid = (sel == 1) ? rv2   : rv1;
  assign o_ready = (sel == 1) ? rr2   : rr1;
  assign o_busy  = (sel == 1) ? busy2 : busy1;
  assign o_rdata = (sel == 1) ? rd2   : rd1;

  cfg_bus_master #(.BUS_W(4), .ADDR_W(8), .DATA_W(8), .TURNAROUND(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(rr1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1), .cfg_frame(fr1), .cfg_bus(bus1)
  );

  cfg_bus_master #(.BUS_W(4), .ADDR_W(8), .DATA_W(8), .TURNAROUND(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(rr2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .busy(busy2), .cfg_frame(fr2), .cfg_bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] tdata;   // target read data
    logic [19:0] beats;  // expected driven beats, first beat in [19:16]
    int         nbeats;
    int         lat;     // accept edge to rsp_valid cycle
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request on instance sel and check every cycle up to one past rsp_valid.
  task automatic run_txn(input int s, input int turn, input vec_t v, input string tag);
    int guard;
    int tstart;
    logic [3:0] eb;
    bit tdrive;
    sel = s;
    @(negedge clk);
    req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    if (s == 1) req_valid2 = 1'b1; else req_valid1 = 1'b1;
    guard = 0;
    while (o_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      chk({tag, "_accept_timeout"}, 0, 1);
      req_valid1 = 1'b0; req_valid2 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid1 = 1'b0; req_valid2 = 1'b0;
    req_write = ~v.wr; req_addr = ~v.addr; req_wdata = ~v.wdata;
    tstart = 1 + 2 + turn + 1;
    for (int k = 1; k <= v.lat + 1; k++) begin
      tdrive = 1'b0;
      t_d = 4'h0;
      if (!v.wr && k == tstart)     begin tdrive = 1'b1; t_d = v.tdata[7:4]; end
      if (!v.wr && k == tstart + 1) begin tdrive = 1'b1; t_d = v.tdata[3:0]; end
      t_oe1 = tdrive && (s == 0);
      t_oe2 = tdrive && (s == 1);
      @(negedge clk);
      if (k <= v.nbeats) eb = v.beats[19 - 4*(k-1) -: 4];
      else if (tdrive)   eb = t_d;
      else               eb = 4'hF;
      chk($sformatf("%s_bus_k%0d", tag, k), 32'(o_bus), 32'(eb));
      chk($sformatf("%s_frame_k%0d", tag, k), 32'(o_frame), 32'(k < v.lat));
      chk($sformatf("%s_valid_k%0d", tag, k), 32'(o_valid), 32'(k == v.lat));
      chk($sformatf("%s_ready_k%0d", tag, k), 32'(o_ready), 32'(k == v.lat + 1));
      chk($sformatf("%s_busy_k%0d", tag, k), 32'(o_busy), 32'(k != v.lat + 1));
      if (k >= v.lat) chk($sformatf("%s_rdata_k%0d", tag, k), 32'(o_rdata), 32'(v.rdata));
      @(posedge clk);
      #1;
    end
    t_oe1 = 1'b0; t_oe2 = 1'b0;
  endtask

  initial begin
    vec_t v3;
    logic [19:0] ba, bb;
    logic [3:0]  eb;

    vecs[0] = '{wr:1'b1, addr:8'hA5, wdata:8'h3C, tdata:8'h00, beats:20'hCA53C, nbeats:5, lat:6, rdata:8'h00};
    vecs[1] = '{wr:1'b0, addr:8'h12, wdata:8'h00, tdata:8'h7E, beats:20'h81200, nbeats:3, lat:7, rdata:8'h7E};
    vecs[2] = '{wr:1'b1, addr:8'h00, wdata:8'hFF, tdata:8'h00, beats:20'hC00FF, nbeats:5, lat:6, rdata:8'h00};
    vecs[3] = '{wr:1'b0, addr:8'hFF, wdata:8'h11, tdata:8'h00, beats:20'h8FF00, nbeats:3, lat:7, rdata:8'h00};
    vecs[4] = '{wr:1'b0, addr:8'h5A, wdata:8'h00, tdata:8'hA5, beats:20'h85A00, nbeats:3, lat:7, rdata:8'hA5};
    vecs[5] = '{wr:1'b1, addr:8'h81, wdata:8'h18, tdata:8'h00, beats:20'hC8118, nbeats:5, lat:6, rdata:8'h00};

    req_valid1 = 1'b0; req_valid2 = 1'b0; req_write = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00;
    t_oe1 = 1'b0; t_oe2 = 1'b0; t_d = 4'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk($sformatf("rst%0d_ready", s), 32'(o_ready), 32'd1);
      chk($sformatf("rst%0d_busy", s),  32'(o_busy),  32'd0);
      chk($sformatf("rst%0d_valid", s), 32'(o_valid), 32'd0);
      chk($sformatf("rst%0d_rdata", s), 32'(o_rdata), 32'd0);
      chk($sformatf("rst%0d_frame", s), 32'(o_frame), 32'd0);
      chk($sformatf("rst%0d_bus", s),   32'(o_bus),   32'hF);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven transactions on the TURNAROUND=1 instance.
    for (int i = 0; i < 6; i++) run_txn(0, 1, vecs[i], $sformatf("v%0d", i));

    // TURNAROUND=3 read: three released framed cycles, response at accept+9.
    v3 = '{wr:1'b0, addr:8'h12, wdata:8'h00, tdata:8'h7E, beats:20'h81200, nbeats:3, lat:9, rdata:8'h7E};
    run_txn(1, 3, v3, "t3");

    // req_valid held across two writes: second accepted after DONE plus one IDLE cycle.
    sel = 0;
    ba = 20'hC3456;
    bb = 20'hC9B2D;
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'h34; req_wdata = 8'h56; req_valid1 = 1'b1;
    chk("b2b_ready0", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    req_addr = 8'h9B; req_wdata = 8'h2D;
    for (int k = 1; k <= 14; k++) begin
      if (k == 8) req_valid1 = 1'b0;
      @(negedge clk);
      if (k <= 5)                eb = ba[19 - 4*(k-1) -: 4];
      else if (k >= 8 && k <= 12) eb = bb[19 - 4*(k-8) -: 4];
      else                       eb = 4'hF;
      chk($sformatf("b2b_bus_k%0d", k),   32'(o_bus),   32'(eb));
      chk($sformatf("b2b_frame_k%0d", k), 32'(o_frame), 32'((k <= 5) || (k >= 8 && k <= 12)));
      chk($sformatf("b2b_valid_k%0d", k), 32'(o_valid), 32'(k == 6 || k == 13));
      chk($sformatf("b2b_ready_k%0d", k), 32'(o_ready), 32'(k == 7 || k == 14));
      @(posedge clk);
      #1;
    end

    // Reset asserted mid-WDATA: bus released and frame low at once, no response.
    sel = 0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'hA5; req_wdata = 8'h3C; req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstmid_bus_before", 32'(o_bus), 32'h3);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_bus",   32'(o_bus),   32'hF);
    chk("rstmid_frame", 32'(o_frame), 32'd0);
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    chk("rstmid_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rstpost_valid_k%0d", k), 32'(o_valid), 32'd0);
      chk($sformatf("rstpost_frame_k%0d", k), 32'(o_frame), 32'd0);
      chk($sformatf("rstpost_ready_k%0d", k), 32'(o_ready), 32'd1);
    end

    // Recovery after reset.
    run_txn(0, 1, vecs[1], "rec");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
